// File: rtl/sram_access_ctrl.sv
// SRAM access controller: zero-fills the macro after reset, then serves
// read/write requests with a credit-guarded two-entry response FIFO.
module sram_access_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 12288
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              rd_busy_q, rd_busy_d;
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [DATA_W-1:0] buf_data_d [2];
  logic              buf_err_q [2];
  logic              buf_err_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic              in_range;
  logic              accept;
  logic              pop;
  logic              push;
  logic [2:0]        held;

  // Slots spoken for once this cycle's pop is taken into account.
  always_comb begin
    in_range  = {1'b0, req_addr} < DEPTH_X;
    pop       = (occ_q != 2'd0) && resp_ready;
    push      = rd_busy_q;
    held      = {1'b0, occ_q} + {2'b0, rd_busy_q} - {2'b0, pop};
    req_ready = (state_q == RUN) && (held < 3'd2);
    accept    = req_valid && req_ready;
  end

  always_comb begin
    resp_valid = occ_q != 2'd0;
    resp_rdata = resp_valid ? buf_data_q[rd_ptr_q] : '0;
    resp_err   = resp_valid && buf_err_q[rd_ptr_q];
    init_done  = state_q == RUN;
  end

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    state_d     = state_q;
    init_addr_d = init_addr_q;
    unique case (state_q)
      INIT: begin
        RW0_en      = 1'b1;
        RW0_wmode   = 1'b1;
        RW0_addr    = init_addr_q;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_A) begin
          state_d     = RUN;
          init_addr_d = '0;
        end
      end
      RUN: begin
        if (accept && in_range) begin
          RW0_en    = 1'b1;
          RW0_wmode = req_write;
          RW0_addr  = req_addr;
          RW0_wdata = req_write ? req_wdata : '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Out-of-range reads travel the same pipeline but land as zero + error.
  always_comb begin
    rd_busy_d = accept && !req_write;
    rd_err_d  = !in_range;
    buf_data_d = buf_data_q;
    buf_err_d  = buf_err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      buf_data_d[wr_ptr_q] = rd_err_q ? '0 : RW0_rdata;
      buf_err_d[wr_ptr_q]  = rd_err_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      rd_busy_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_err_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      rd_busy_q   <= rd_busy_d;
      rd_err_q    <= rd_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      buf_data_q  <= buf_data_d;
      buf_err_q   <= buf_err_d;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_sram_access_ctrl;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 12288;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          init_done;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;

  always #5 clock = ~clock;

  sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // SRAM macro model, pre-loaded with junk so zero-fill is observable
  logic          junk = 1'b1;
  logic [DW-1:0] sram [0:DEPTH-1];
  always @(posedge clock) begin
    if (junk) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= DW'(32'hA500_0000 | i);
    end else if (RW0_en && int'(RW0_addr) < DEPTH) begin
      if (RW0_wmode) sram[RW0_addr] <= RW0_wdata;
      else RW0_rdata <= sram[RW0_addr];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    resp_ready = rr;
  endtask

  // Call at a negedge where reset has just been released.
  task automatic run_init();
    int n;
    int bad;
    n = 0;
    bad = 0;
    for (int c = 0; c < DEPTH + 100; c++) begin
      #1;
      if (init_done === 1'b1) break;
      if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_addr === AW'(n) &&
            RW0_wdata === '0 && req_ready === 1'b0 && resp_valid === 1'b0))
        bad++;
      n++;
      @(negedge clock);
    end
    check("init_count", 64'(n), 64'(DEPTH));
    check("init_cycles_bad", 64'(bad), 64'(0));
    check("init_done_after", 64'(init_done), 64'(1));
    check("ready_after_init", 64'(req_ready), 64'(1));
    check("en_idle_after_init", 64'(RW0_en), 64'(0));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  typedef struct {
    logic          v, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rr;
    logic          e_rdy, e_en, e_wm;
    logic [DW-1:0] e_wd;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_err;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic w, logic [AW-1:0] a,
      logic [DW-1:0] d, logic rr, logic e_rdy, logic e_en, logic e_wm,
      logic [DW-1:0] e_wd, logic e_rv, logic [DW-1:0] e_rd, logic e_err);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.rr = rr;
    t.e_rdy = e_rdy; t.e_en = e_en; t.e_wm = e_wm; t.e_wd = e_wd;
    t.e_rv = e_rv; t.e_rd = e_rd; t.e_err = e_err;
    return t;
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            vis;
  } rsp_t;
  rsp_t exq[$];

  initial begin
    int first, last, cnt, stale;
    // write then read back
    tbl.push_back(mk(1,1,14'h10,32'hDEADBEEF,1, 1,1,1,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(1,0,14'h10,0,1,           1,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,                1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,                1,0,0,0,1,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,0,0,1,                1,0,0,0,0,0,0));
    // out-of-range read and write
    tbl.push_back(mk(1,0,14'd12288,0,1,        1,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,14'd12300,32'h12345678,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,                1,0,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,1,                1,0,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,1,                1,0,0,0,0,0,0));
    // back-pressure: two reads fit, third waits for a pop
    tbl.push_back(mk(1,1,1,32'h11111111,0,     1,1,1,32'h11111111,0,0,0));
    tbl.push_back(mk(1,1,2,32'h22222222,0,     1,1,1,32'h22222222,0,0,0));
    tbl.push_back(mk(1,1,3,32'h33333333,0,     1,1,1,32'h33333333,0,0,0));
    tbl.push_back(mk(1,0,1,0,0,                1,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,2,0,0,                1,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,3,0,0,                0,0,0,0,1,32'h11111111,0));
    tbl.push_back(mk(1,0,3,0,0,                0,0,0,0,1,32'h11111111,0));
    tbl.push_back(mk(1,0,3,0,1,                1,1,0,0,1,32'h11111111,0));
    tbl.push_back(mk(0,0,0,0,1,                1,0,0,0,1,32'h22222222,0));
    tbl.push_back(mk(0,0,0,0,1,                1,0,0,0,1,32'h33333333,0));
    tbl.push_back(mk(0,0,0,0,1,                1,0,0,0,0,0,0));

    // reset state
    @(negedge clock);
    junk = 1'b0;
    @(negedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_err", 64'(resp_err), 64'(0));
    check("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    run_init();

    foreach (tbl[i]) begin
      @(negedge clock);
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rr);
      #1;
      check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
      check($sformatf("v%0d_en", i), 64'(RW0_en), 64'(tbl[i].e_en));
      check($sformatf("v%0d_wmode", i), 64'(RW0_wmode), 64'(tbl[i].e_wm));
      if (tbl[i].e_en)
        check($sformatf("v%0d_addr", i), 64'(RW0_addr), 64'(tbl[i].a));
      check($sformatf("v%0d_wdata", i), 64'(RW0_wdata), 64'(tbl[i].e_wd));
      check($sformatf("v%0d_rvalid", i), 64'(resp_valid), 64'(tbl[i].e_rv));
      check($sformatf("v%0d_rdata", i), 64'(resp_rdata), 64'(tbl[i].e_rd));
      check($sformatf("v%0d_err", i), 64'(resp_err), 64'(tbl[i].e_err));
      if (tbl[i].v && tbl[i].w && tbl[i].e_rdy && int'(tbl[i].a) < DEPTH)
        ref_mem[tbl[i].a] = tbl[i].d;
    end

    // back-to-back reads of 0..15
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      drive(c < 16, 1'b0, AW'(c < 16 ? c : 0), '0, 1'b1);
      #1;
      if (c < 16) check($sformatf("b2b_ready_%0d", c), 64'(req_ready), 64'(1));
      if (resp_valid) begin
        if (first < 0) first = c;
        last = c;
        check($sformatf("b2b_data_%0d", cnt), 64'(resp_rdata), 64'(ref_mem[cnt]));
        cnt++;
      end
    end
    check("b2b_count", 64'(cnt), 64'(16));
    check("b2b_first", 64'(first), 64'(2));
    check("b2b_last", 64'(last), 64'(17));

    // reset with one buffered response and one read in flight
    @(negedge clock);
    drive(1'b1, 1'b0, 14'd5, '0, 1'b0);
    @(negedge clock);
    drive(1'b1, 1'b0, 14'd6, '0, 1'b0);
    @(negedge clock);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    check("pre_rst_valid", 64'(resp_valid), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    check("mid_rst_init_done", 64'(init_done), 64'(0));
    check("mid_rst_rdata", 64'(resp_rdata), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    run_init();
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      #1;
      if (resp_valid !== 1'b0) stale++;
    end
    check("no_stale_resp", 64'(stale), 64'(0));

    // randomized run against the queue model
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic          v, w, rr, ev, pop, erdy, acc, inr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      @(negedge clock);
      v  = $urandom_range(0, 3) != 0;
      w  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) != 3) ? AW'($urandom_range(0, 31))
                                        : AW'($urandom_range(DEPTH - 4, 16383));
      d  = $urandom;
      rr = $urandom_range(0, 3) != 0;
      drive(v, w, a, d, rr);
      #1;
      ev   = exq.size() > 0 && exq[0].vis <= cyc;
      pop  = ev && rr;
      erdy = (exq.size() - (pop ? 1 : 0)) < 2;
      acc  = v && erdy;
      inr  = int'(a) < DEPTH;
      check($sformatf("r%0d_ready", cyc), 64'(req_ready), 64'(erdy));
      check($sformatf("r%0d_rvalid", cyc), 64'(resp_valid), 64'(ev));
      if (ev) begin
        check($sformatf("r%0d_rdata", cyc), 64'(resp_rdata), 64'(exq[0].d));
        check($sformatf("r%0d_err", cyc), 64'(resp_err), 64'(exq[0].e));
      end
      check($sformatf("r%0d_en", cyc), 64'(RW0_en), 64'(acc && inr));
      check($sformatf("r%0d_wmode", cyc), 64'(RW0_wmode), 64'(acc && inr && w));
      if (acc && inr)
        check($sformatf("r%0d_addr", cyc), 64'(RW0_addr), 64'(a));
      check($sformatf("r%0d_wdata", cyc), 64'(RW0_wdata),
            64'((acc && inr && w) ? d : '0));
      if (pop) void'(exq.pop_front());
      if (acc && !w) begin
        rsp_t r;
        r.d   = inr ? ref_mem[a] : '0;
        r.e   = !inr;
        r.vis = cyc + 2;
        exq.push_back(r);
      end
      if (acc && w && inr) ref_mem[a] = d;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
